// File: rtl/xbus_pkg.sv
// Shared XBUS definitions: FSM states, size encodings, request record and the
// big-endian lane helpers used by both master and slave-side blocks.
package xbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } xbus_state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [1:0]  size;
    } xbus_req_t;

    localparam int unsigned XBUS_REQ_W = $bits(xbus_req_t);

    function automatic logic xbus_legal(input logic [1:0] size, input logic [1:0] off);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~off[0];
            SZ_WORD: ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Lane 3 (be[3], data[31:24]) holds the lowest byte address.
    function automatic logic [3:0] xbus_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b1000 >> off;
            SZ_HALF: be = off[1] ? 4'b0011 : 4'b1100;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] xbus_replicate(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] rep;
        case (size)
            SZ_BYTE: rep = {4{data[7:0]}};
            SZ_HALF: rep = {2{data[15:0]}};
            default: rep = data;
        endcase
        return rep;
    endfunction

    function automatic logic [31:0] xbus_extract(input logic [1:0] size, input logic [1:0] off,
                                                 input logic [31:0] data);
        logic [31:0] shifted;
        logic [31:0] res;
        shifted = data >> {~off, 3'b000};
        case (size)
            SZ_BYTE: res = {24'h000000, shifted[7:0]};
            SZ_HALF: res = off[1] ? {16'h0000, data[15:0]} : {16'h0000, data[31:16]};
            SZ_WORD: res = data;
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/xbus_master_if.sv
// Request/response handshake plus XBUS strobe and slave completion signals.
interface xbus_master_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic [1:0]  req_size;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        xbs_select;
    logic [31:0] xbs_addr;
    logic [31:0] xbs_data;
    logic        xbs_rnw;
    logic [3:0]  xbs_be;

    logic        sl_ack;
    logic [31:0] sl_data;

    modport master (
        input  req_valid, req_addr, req_wdata, req_we, req_size,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output xbs_select, xbs_addr, xbs_data, xbs_rnw, xbs_be,
        input  sl_ack, sl_data
    );

    modport slave (
        output req_valid, req_addr, req_wdata, req_we, req_size,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  xbs_select, xbs_addr, xbs_data, xbs_rnw, xbs_be,
        output sl_ack, sl_data
    );

endinterface

// File: rtl/xbus_req_fifo.sv
// Request buffer: DEPTH-entry synchronous FIFO; a pop frees room for a
// same-cycle push even when full.
module xbus_req_fifo #(
    parameter int unsigned WIDTH = 67,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/xbus_master.sv
// XBUS master: buffers load/store requests and runs each as a one-cycle
// XBUS strobe, returning exactly one response per request.
module xbus_master
    import xbus_pkg::*;
#(
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    xbus_master_if.master bus
);

    localparam int unsigned   CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    xbus_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   xbs_addr_q, xbs_addr_d;
    logic [31:0]   xbs_data_q, xbs_data_d;
    logic          xbs_rnw_q, xbs_rnw_d;
    logic [3:0]    xbs_be_q, xbs_be_d;
    logic [1:0]    size_q, size_d;
    logic [1:0]    off_q, off_d;
    logic          rsp_err_q, rsp_err_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;

    xbus_req_t fifo_din;
    xbus_req_t fifo_dout;
    logic      fifo_push;
    logic      fifo_pop;
    logic      fifo_full;
    logic      fifo_empty;
    logic      head_legal;

    always_comb begin
        fifo_din.addr  = bus.req_addr;
        fifo_din.wdata = bus.req_wdata;
        fifo_din.we    = bus.req_we;
        fifo_din.size  = bus.req_size;
    end

    assign bus.req_ready = ~fifo_full & ~rst;
    assign fifo_push     = bus.req_valid & bus.req_ready;
    assign head_legal    = xbus_legal(fifo_dout.size, fifo_dout.addr[1:0]);

    xbus_req_fifo #(
        .WIDTH(XBUS_REQ_W),
        .DEPTH(FIFO_DEPTH)
    ) u_req_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (fifo_push),
        .din  (fifo_din),
        .pop  (fifo_pop),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            xbs_addr_q  <= '0;
            xbs_data_q  <= '0;
            xbs_rnw_q   <= 1'b1;
            xbs_be_q    <= '0;
            size_q      <= SZ_BYTE;
            off_q       <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            xbs_addr_q  <= xbs_addr_d;
            xbs_data_q  <= xbs_data_d;
            xbs_rnw_q   <= xbs_rnw_d;
            xbs_be_q    <= xbs_be_d;
            size_q      <= size_d;
            off_q       <= off_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // An ack in the final WAIT cycle wins over the timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (!fifo_empty) state_d = head_legal ? ST_ISSUE : ST_RESP;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (bus.sl_ack || (cnt_q == LAST_WAIT)) state_d = ST_RESP;
            ST_RESP:  if (bus.rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_pop    = 1'b0;
        cnt_d       = cnt_q;
        xbs_addr_d  = xbs_addr_q;
        xbs_data_d  = xbs_data_q;
        xbs_rnw_d   = xbs_rnw_q;
        xbs_be_d    = xbs_be_q;
        size_d      = size_q;
        off_d       = off_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (head_legal) begin
                        xbs_addr_d = {2'b00, fifo_dout.addr[31:2]};
                        xbs_data_d = xbus_replicate(fifo_dout.size, fifo_dout.wdata);
                        xbs_rnw_d  = ~fifo_dout.we;
                        xbs_be_d   = xbus_be(fifo_dout.size, fifo_dout.addr[1:0]);
                        size_d     = fifo_dout.size;
                        off_d      = fifo_dout.addr[1:0];
                    end else begin
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
            end
            ST_ISSUE: cnt_d = '0;
            ST_WAIT: begin
                if (bus.sl_ack) begin
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = xbs_rnw_q ? xbus_extract(size_q, off_q, bus.sl_data) : '0;
                end else if (cnt_q == LAST_WAIT) begin
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
            end
            default: begin
            end
        endcase
    end

    assign bus.xbs_select = (state_q == ST_ISSUE);
    assign bus.xbs_addr   = xbs_addr_q;
    assign bus.xbs_data   = xbs_data_q;
    assign bus.xbs_rnw    = xbs_rnw_q;
    assign bus.xbs_be     = xbs_be_q;
    assign bus.rsp_valid  = (state_q == ST_RESP);
    assign bus.rsp_err    = rsp_err_q;
    assign bus.rsp_rdata  = rsp_rdata_q;

endmodule

// File: doc/xbus_master.md
XBUS_MASTER -- requirements
Module: xbus_master

Interface
REQ-001 Parameter TIMEOUT, default 64, meaning: cycles waited in WAIT for sl_ack before an error response is returned.
REQ-002 Parameter FIFO_DEPTH, default 2, meaning: request buffer entries, power of two, at least 2.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  1  request offered.
REQ-006 req_ready  out  1  request buffer not full.
REQ-007 req_addr  in  32  byte address.
REQ-008 req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 req_we  in  1  1=store, 0=load.
REQ-010 req_size  in  2  0=byte, 1=half, 2=word, 3=reserved.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  response consumed.
REQ-013 rsp_rdata  out  32  load data, zero-extended and right-aligned; 0 for stores and errors.
REQ-014 rsp_err  out  1  misaligned, reserved size, or timeout.
REQ-015 xbs_select  out  1  one-cycle transaction strobe.
REQ-016 xbs_addr  out  32  word address (req_addr>>2).
REQ-017 xbs_data  out  32  store data replicated into addressed lanes.
REQ-018 xbs_rnw  out  1  1=read, 0=write.
REQ-019 xbs_be  out  4  byte enables, be[3]=MSB lane.
REQ-020 sl_ack  in  1  one-cycle completion from slave.
REQ-021 sl_data  in  32  read data; valid in the cycle sl_ack=1.

Function
REQ-022 Accept on req_valid&&req_ready into a FIFO_DEPTH-entry FIFO; req_ready=0 when full; a push and pop in the same cycle when full are both allowed.
REQ-023 FSM states IDLE, ISSUE, WAIT, RESP; IDLE->ISSUE when FIFO non-empty and the entry is legal, popping it.
REQ-024 An illegal entry (size 3, half with addr[0]=1, word with addr[1:0]!=0) shall go IDLE->RESP with rsp_err=1 and no bus cycle.
REQ-025 ISSUE shall last exactly one cycle with xbs_select=1 and the address, data, rnw and be fields stable, then go to WAIT.
REQ-026 Big-endian lanes: byte offset o gives be=4'b1000>>o; half gives 1100 (o=0) or 0011 (o=2); word gives 1111.
REQ-027 xbs_data: byte replicated 4x; half replicated 2x; word unchanged.
REQ-028 WAIT->RESP on sl_ack=1; a load captures the addressed lane(s) of sl_data, shifted right and zero-extended, into rsp_rdata.
REQ-029 WAIT counter starts at 0 on entry; when it reaches TIMEOUT with no ack, go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-030 RESP holds rsp_valid=1 with stable fields until rsp_ready=1, then goes to IDLE; back-to-back issue resumes next cycle (min 1 idle cycle between transactions).
REQ-031 sl_ack outside WAIT shall be ignored (late ack after timeout).
REQ-032 xbs_select=0 in every state except ISSUE; xbs_* hold their last values otherwise.

Reset
REQ-033 rst=1 shall immediately force: FSM=IDLE, FIFO empty, req_ready=0 while rst=1 and 1 after, rsp_valid=0, rsp_err=0, rsp_rdata=0, xbs_select=0, xbs_addr=0, xbs_data=0, xbs_rnw=1, xbs_be=0, counter=0.
REQ-034 Reset mid-transaction shall drop the transaction with no response; a subsequent stray sl_ack is ignored per REQ-031.

Structure
REQ-035 Package xbus_pkg shall hold the state enum, the size encoding constants, and the be/lane-replicate/extract functions, shared with the slave-side blocks.
REQ-036 The request buffer shall be sub-module xbus_req_fifo (parameterised width/depth, synchronous push/pop, full/empty).

Verification
REQ-037 Word store addr 0x10, data 0xDEADBEEF, then word load 0x10 against the memctrl model (MEMDELAY=1) -> xbs_addr=4, be=1111, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-038 Byte store 0xAB to addr 0x21 -> xbs_be=0100, xbs_data=0xABABABAB; word load 0x20 -> byte [23:16]=0xAB, others unchanged.
REQ-039 Half load addr 0x22 on word 0x11223344 -> be=0011, rsp_rdata=0x00003344; half load at addr 0x23 -> rsp_err=1, xbs_select never asserted.
REQ-040 Slave never acks, TIMEOUT=8 -> rsp_valid 8 cycles after WAIT entry, rsp_err=1, rsp_rdata=0; injected late ack is ignored.
REQ-041 Push 3 requests back-to-back with rsp_ready=0 -> req_ready=0 after the FIFO fills; releasing rsp_ready drains all in order with exactly one xbs_select per request.
REQ-042 Assert rst during WAIT -> all outputs at reset values in the same cycle, no rsp_valid afterwards, next request completes normally.
